// File: rtl/gpr_wb_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | gpr_wb_queue : in-order write-back FIFO feeding the GPR write port, with  |
// |                read-port forwarding of pending values.                    |
// | Optional: GPR_WB_BYPASS_EN enables the rd_hit_*/rd_data_* match logic.    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module gpr_wb_queue #(
   parameter int DEPTH = 4,
   parameter int DW    = 32,
   parameter int AW    = 5
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   input  logic [AW-1:0]            in_addr,
   input  logic [DW-1:0]            in_data,
   input  logic                     link_valid,
   input  logic [DW-1:0]            link_data,
   output logic                     in_ready,
   input  logic                     wr_hold,
   output logic                     RegWrite,
   output logic [AW-1:0]            writeAddr,
   output logic [DW-1:0]            writeData,
   input  logic [AW-1:0]            rd_addr_1,
   input  logic [AW-1:0]            rd_addr_2,
   output logic                     rd_hit_1,
   output logic                     rd_hit_2,
   output logic [DW-1:0]            rd_data_1,
   output logic [DW-1:0]            rd_data_2,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [AW-1:0] LINK_REG  = AW'(31);
   localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - 2);

   logic [AW-1:0] q_addr [DEPTH];
   logic [DW-1:0] q_data [DEPTH];
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [PW-1:0] link_slot;
   logic          accept;
   logic          prim_push;
   logic          link_push;
   logic          pop;
   logic [1:0]    pushed;
   logic          occupied;

   // A bundle needs two free slots regardless of its actual size.
   assign in_ready  = !reset || (count <= READY_MAX);
   assign accept    = in_valid && in_ready;
   assign prim_push = accept && (in_addr != '0);
   assign link_push = accept && link_valid;
   assign pushed    = {1'b0, prim_push} + {1'b0, link_push};
   assign link_slot = tail + PW'(prim_push);

   assign occupied  = reset && (count != '0);
   assign RegWrite  = occupied && !wr_hold;
   assign pop       = RegWrite;
   assign writeAddr = occupied ? q_addr[head] : '0;
   assign writeData = occupied ? q_data[head] : '0;

   always_ff @(posedge clk) begin
      if (!reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (pop) begin
            head <= head + PW'(1);
         end
         tail  <= tail + PW'(pushed);
         count <= count + CW'(pushed) - CW'(pop);
      end
   end

   // Payload storage needs no reset; occupancy is tracked by the pointers.
   always_ff @(posedge clk) begin
      if (prim_push) begin
         q_addr[tail] <= in_addr;
         q_data[tail] <= in_data;
      end
      if (link_push) begin
         q_addr[link_slot] <= LINK_REG;
         q_data[link_slot] <= link_data;
      end
   end

`ifdef GPR_WB_BYPASS_EN
   // Walk oldest to youngest so the last match found is the newest value.
   always_comb begin
      logic [PW-1:0] slot;
      slot      = '0;
      rd_hit_1  = 1'b0;
      rd_hit_2  = 1'b0;
      rd_data_1 = '0;
      rd_data_2 = '0;
      for (int k = 0; k < DEPTH; k++) begin
         slot = head + PW'(k);
         if (CW'(k) < count) begin
            if ((rd_addr_1 != '0) && (q_addr[slot] == rd_addr_1)) begin
               rd_hit_1  = 1'b1;
               rd_data_1 = q_data[slot];
            end
            if ((rd_addr_2 != '0) && (q_addr[slot] == rd_addr_2)) begin
               rd_hit_2  = 1'b1;
               rd_data_2 = q_data[slot];
            end
         end
      end
      if (!reset) begin
         rd_hit_1  = 1'b0;
         rd_hit_2  = 1'b0;
         rd_data_1 = '0;
         rd_data_2 = '0;
      end
   end
`else
   logic unused_rd_addr;
   assign unused_rd_addr = ^{rd_addr_1, rd_addr_2};
   assign rd_hit_1  = 1'b0;
   assign rd_hit_2  = 1'b0;
   assign rd_data_1 = '0;
   assign rd_data_2 = '0;
`endif

endmodule
`default_nettype wire
